adsr_envelope: RTL and testbench
================================

ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 SHALL have parameter PRESCALE, default 1024: clock cycles per envelope tick, legal range 2..65536.
REQ-002 SHALL have port clk, input, 1: the single clock, the synthesizer system clock.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port gate, input, 1: note on (1) or off (0), synchronous to clk.
REQ-005 SHALL have port note_duty, input, 16: full-scale duty word, the core's pwm_reg value.
REQ-006 SHALL have port attack_rate, input, 8: level increment per tick; 0 means instant.
REQ-007 SHALL have port decay_rate, input, 8: level decrement per tick; 0 means instant.
REQ-008 SHALL have port sustain_level, input, 8: sustain target level.
REQ-009 SHALL have port release_rate, input, 8: level decrement per tick; 0 means instant.
REQ-010 SHALL have port duty_out, output, 16: scaled duty word, feeds the pwm_reg input of a pwm channel.
REQ-011 SHALL have port env_level, output, 8: current envelope level.
REQ-012 SHALL have port env_state, output, 3: current state (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4).
REQ-013 SHALL have port active, output, 1: high whenever env_state is not IDLE.

Function
REQ-014 SHALL run a free-running prescaler that asserts an internal tick for 1 cycle every PRESCALE cycles; the first tick comes PRESCALE cycles after reset release.
REQ-015 SHALL register gate into gate_q every clock: rise = gate & ~gate_q, fall = ~gate & gate_q.
REQ-016 SHALL, on rise in any state, enter ATTACK on the next clock.
REQ-017 SHALL, on fall in ATTACK, DECAY or SUSTAIN, enter RELEASE on the next clock; a fall in IDLE or RELEASE has no effect.
REQ-018 SHALL give a gate edge priority over a tick in the same cycle; env_level does not change in that cycle.
REQ-019 SHALL, in ATTACK on a tick, set level = min(level + attack_rate, 255), treating a rate of 0 as 255; on reaching 255 it enters DECAY.
REQ-020 SHALL, in DECAY on a tick, set level = max(level - decay_rate, sustain_level), treating a rate of 0 as 255; when level equals sustain_level it enters SUSTAIN, and with sustain_level = 255 this happens on the first tick.
REQ-021 SHALL, in SUSTAIN on each tick, load level from sustain_level, which is read live.
REQ-022 SHALL, in RELEASE on a tick, set level = max(level - release_rate, 0), treating a rate of 0 as 255; on reaching 0 it enters IDLE.
REQ-023 SHALL compute all level arithmetic at 9 bits and clamp it; level never wraps.
REQ-024 SHALL read the rate inputs live at each tick, with no latching.
REQ-025 SHALL register duty_out = (note_duty * (level + 1)) >> 8 when level != 0, and 0 when level = 0; latency is exactly 1 clock from a change of level or note_duty.
REQ-026 SHALL make env_level, env_state and active registered outputs that are mutually consistent in every cycle.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously force duty_out = 0, env_level = 0, env_state = IDLE, active = 0, gate_q = 0 and the prescaler count = 0.
REQ-028 SHALL, when reset is asserted mid-envelope, abort the envelope; after release the block stays in IDLE until a fresh rise. A gate held high through reset counts as a rise on the first clock after release.

Configuration
REQ-029 SHALL support the macro ADSR_RETRIGGER_EN: when defined, a rise clears level to 0 on the same clock that ATTACK is entered; when undefined, ATTACK continues from the current level (legato).

Structure
REQ-030 SHALL declare the env_state encoding (enum/constants IDLE..RELEASE) and the LEVEL_MAX = 255 constant in the shared package synth_pkg.
REQ-031 SHALL implement the prescaler as the sub-module adsr_tick_gen (parameter PRESCALE; ports clk, rst_n, tick).

Verification
REQ-032 SHALL cover attack to sustain: PRESCALE=4, attack_rate=64, decay_rate=32, sustain_level=128, note_duty=0x8000, gate high. Required: levels 64, 128, 192, 255, then 223, 191, 159, 128, then SUSTAIN; duty_out=0x4080 one clock after level 128.
REQ-033 SHALL cover release to idle: from SUSTAIN at level 128 with release_rate=50, drop gate. Required: RELEASE next clock; levels 78, 28, 0; then IDLE with active=0 and duty_out=0.
REQ-034 SHALL cover instant rates: attack_rate=0, decay_rate=0, sustain_level=255. Required: level 255 on the first tick, SUSTAIN on the second tick, duty_out equal to note_duty.
REQ-035 SHALL cover retrigger: rise during RELEASE at level 100. Required: ATTACK next clock, with level 0 if ADSR_RETRIGGER_EN is defined and 100 if not; rerun both builds.
REQ-036 SHALL cover edge/tick collision and reset: a fall coincident with a tick gives RELEASE with level unchanged that cycle; rst_n low mid-ATTACK forces all outputs to 0 or IDLE immediately, before any clock edge.

Source files
------------

// File: rtl/synth_pkg.sv
// ----------------------------------------------------------------------------
// synth_pkg -- shared definitions for the synthesizer envelope slice.
//
// Contents:
//   env_state_t  : envelope state encoding (IDLE..RELEASE), 3 bits wide
//   LEVEL_MAX    : full-scale envelope level (255)
//   eff_rate()   : maps a rate of 0 to "instant", i.e. LEVEL_MAX
//   scale_duty() : duty word scaled by (level + 1) / 256, 0 at level 0
// ----------------------------------------------------------------------------
package synth_pkg;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  localparam logic [7:0] LEVEL_MAX = 8'd255;

  // A rate of 0 means "reach the target in one tick", which a full-scale
  // step always does.
  function automatic logic [7:0] eff_rate(input logic [7:0] rate);
    return (rate == 8'd0) ? LEVEL_MAX : rate;
  endfunction

  // (level + 1) keeps level 255 at exactly full scale; level 0 is a hard
  // mute instead of 1/256 of the duty word.
  function automatic logic [15:0] scale_duty(input logic [15:0] duty,
                                             input logic [7:0]  level);
    logic [24:0] prod;
    prod = 25'(duty) * 25'({1'b0, level} + 9'd1);
    return (level == 8'd0) ? 16'd0 : 16'(prod >> 8);
  endfunction

endpackage

// File: rtl/adsr_tick_gen.sv
// ----------------------------------------------------------------------------
// adsr_tick_gen -- free-running prescaler producing the envelope tick.
//
// Parameters:
//   PRESCALE : clock cycles per tick, 2..65536
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : registered one-cycle pulse every PRESCALE cycles; the first
//           pulse is consumed by the PRESCALE-th clock edge after reset
// ----------------------------------------------------------------------------
module adsr_tick_gen #(
  parameter int PRESCALE = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int                CNT_W    = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);
  // tick is registered, so it is raised one count early
  localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(PRESCALE - 2);

  logic [CNT_W-1:0] count_r;
  logic             tick_r;

  // Prescale counter and registered tick pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      if (count_r == CNT_LAST) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CNT_W'(1);
      end
      tick_r <= (count_r == CNT_PRE);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/adsr_envelope.sv
// ----------------------------------------------------------------------------
// adsr_envelope -- ADSR envelope generator scaling a PWM duty word.
//
// Parameters:
//   PRESCALE      : clock cycles per envelope tick, 2..65536
// Ports:
//   clk           : synthesizer system clock
//   rst_n         : asynchronous active-low reset
//   gate          : note on (1) / off (0)
//   note_duty     : full-scale duty word (16 bits)
//   attack_rate   : level increment per tick, 0 = instant
//   decay_rate    : level decrement per tick, 0 = instant
//   sustain_level : sustain target level, read live
//   release_rate  : level decrement per tick, 0 = instant
//   duty_out      : note_duty scaled by the envelope level (registered)
//   env_level     : current envelope level (registered)
//   env_state     : current state, synth_pkg::env_state_t encoding
//   active        : high whenever env_state is not IDLE
//
// Build option:
//   ADSR_RETRIGGER_EN : when defined, a gate rise restarts the attack from
//                       level 0; otherwise the attack continues from the
//                       current level (legato).
// ----------------------------------------------------------------------------
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int PRESCALE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gate,
  input  logic [15:0] note_duty,
  input  logic [7:0]  attack_rate,
  input  logic [7:0]  decay_rate,
  input  logic [7:0]  sustain_level,
  input  logic [7:0]  release_rate,
  output logic [15:0] duty_out,
  output logic [7:0]  env_level,
  output logic [2:0]  env_state,
  output logic        active
);

  logic       tick_s;
  logic       gate_q_r;
  logic       rise_s;
  logic       fall_s;
  env_state_t state_r;
  env_state_t state_nxt_s;
  logic [7:0] level_r;
  logic [7:0] level_nxt_s;
  logic       active_r;
  logic [15:0] duty_r;
  logic [8:0] att_sum_s;
  logic [8:0] dec_diff_s;
  logic [8:0] rel_diff_s;

  adsr_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  assign rise_s = gate & ~gate_q_r;
  assign fall_s = ~gate & gate_q_r;

  // 9-bit arithmetic: bit 8 flags overflow (attack) or borrow (decay/release)
  assign att_sum_s  = {1'b0, level_r} + {1'b0, eff_rate(attack_rate)};
  assign dec_diff_s = {1'b0, level_r} - {1'b0, eff_rate(decay_rate)};
  assign rel_diff_s = {1'b0, level_r} - {1'b0, eff_rate(release_rate)};

  // Next state and level: gate edges first, then tick-driven level steps
  always_comb begin
    state_nxt_s = state_r;
    level_nxt_s = level_r;
    if (rise_s) begin
      state_nxt_s = ENV_ATTACK;
`ifdef ADSR_RETRIGGER_EN
      level_nxt_s = 8'd0;
`else
      level_nxt_s = level_r;
`endif
    end else if (fall_s) begin
      if ((state_r == ENV_ATTACK) || (state_r == ENV_DECAY) ||
          (state_r == ENV_SUSTAIN)) begin
        state_nxt_s = ENV_RELEASE;
      end else begin
        state_nxt_s = state_r;
      end
    end else if (tick_s) begin
      case (state_r)
        ENV_IDLE: begin
          state_nxt_s = ENV_IDLE;
        end
        ENV_ATTACK: begin
          if (att_sum_s >= 9'd255) begin
            level_nxt_s = LEVEL_MAX;
            state_nxt_s = ENV_DECAY;
          end else begin
            level_nxt_s = att_sum_s[7:0];
          end
        end
        ENV_DECAY: begin
          // Clamp at sustain; also covers sustain raised above the level
          if (dec_diff_s[8] || (dec_diff_s[7:0] <= sustain_level)) begin
            level_nxt_s = sustain_level;
            state_nxt_s = ENV_SUSTAIN;
          end else begin
            level_nxt_s = dec_diff_s[7:0];
          end
        end
        ENV_SUSTAIN: begin
          level_nxt_s = sustain_level;
        end
        ENV_RELEASE: begin
          if (rel_diff_s[8] || (rel_diff_s[7:0] == 8'd0)) begin
            level_nxt_s = 8'd0;
            state_nxt_s = ENV_IDLE;
          end else begin
            level_nxt_s = rel_diff_s[7:0];
          end
        end
        default: begin
          state_nxt_s = ENV_IDLE;
          level_nxt_s = 8'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      level_nxt_s = level_r;
    end
  end

  // State, level, active flag and scaled duty registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q_r <= 1'b0;
      state_r  <= ENV_IDLE;
      level_r  <= 8'd0;
      active_r <= 1'b0;
      duty_r   <= 16'd0;
    end else begin
      gate_q_r <= gate;
      state_r  <= state_nxt_s;
      level_r  <= level_nxt_s;
      // derived from the same next state so it always matches env_state
      active_r <= (state_nxt_s != ENV_IDLE);
      duty_r   <= scale_duty(note_duty, level_r);
    end
  end

  assign duty_out  = duty_r;
  assign env_level = level_r;
  assign env_state = state_r;
  assign active    = active_r;

endmodule

// File: tb/tb_adsr_envelope.sv
module tb_adsr_envelope;

  localparam int P = 4;

  logic        clk;
  logic        rst_n;
  logic        gate;
  logic [15:0] note_duty;
  logic [7:0]  attack_rate;
  logic [7:0]  decay_rate;
  logic [7:0]  sustain_level;
  logic [7:0]  release_rate;
  logic [15:0] duty_out;
  logic [7:0]  env_level;
  logic [2:0]  env_state;
  logic        active;

  int n_vec;
  int n_err;

  // reference model state (plain integers, spec-level rules)
  int m_state;   // 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
  int m_level;
  int m_duty;
  int m_gq;
  int edge_n;    // clock edges since reset release

  adsr_envelope #(.PRESCALE(P)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gate          (gate),
    .note_duty     (note_duty),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .duty_out      (duty_out),
    .env_level     (env_level),
    .env_state     (env_state),
    .active        (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic int rate_of(input logic [7:0] r);
    return (r == 8'd0) ? 255 : int'(r);
  endfunction

  // One clock edge of the envelope, from the written rules
  task automatic model_edge();
    bit rise, fall, tk;
    int g;
    g = int'(gate);
    edge_n++;
    tk = ((edge_n % P) == 0);
    m_duty = (m_level == 0) ? 0 : (int'(note_duty) * (m_level + 1)) / 256;
    rise = (g == 1) && (m_gq == 0);
    fall = (g == 0) && (m_gq == 1);
    if (rise) begin
      m_state = 1;
`ifdef ADSR_RETRIGGER_EN
      m_level = 0;
`endif
    end else if (fall) begin
      if (m_state >= 1 && m_state <= 3) m_state = 4;
    end else if (tk) begin
      case (m_state)
        1: begin
          m_level = m_level + rate_of(attack_rate);
          if (m_level >= 255) begin m_level = 255; m_state = 2; end
        end
        2: begin
          m_level = m_level - rate_of(decay_rate);
          if (m_level <= int'(sustain_level)) begin
            m_level = int'(sustain_level);
            m_state = 3;
          end
        end
        3: m_level = int'(sustain_level);
        4: begin
          m_level = m_level - rate_of(release_rate);
          if (m_level <= 0) begin m_level = 0; m_state = 0; end
        end
        default: ;
      endcase
    end
    m_gq = g;
  endtask

  task automatic model_reset();
    m_state = 0; m_level = 0; m_duty = 0; m_gq = 0; edge_n = 0;
  endtask

  // advance one clock, update the model, compare on the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("level",  env_level, m_level);
    check("state",  env_state, m_state);
    check("active", active,    (m_state != 0) ? 1 : 0);
    check("duty",   duty_out,  m_duty);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [7:0] pick_rate();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return 8'd0;
    if (k <= 4) return 8'($urandom_range(1, 80));
    return 8'($urandom);
  endfunction

  int saved;
  int k;

  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    rst_n = 1'b0; gate = 1'b0; note_duty = 16'h8000;
    attack_rate = 8'd64; decay_rate = 8'd32; sustain_level = 8'd128;
    release_rate = 8'd50;
    @(negedge clk); @(negedge clk);
    check("rst_level",  env_level, 0);
    check("rst_state",  env_state, 0);
    check("rst_active", active,    0);
    check("rst_duty",   duty_out,  0);
    rst_n = 1'b1;

    // attack -> decay -> sustain
    gate = 1'b1;
    run(40);
    check("s1_state", env_state, 3);
    check("s1_level", env_level, 128);
    check("s1_duty",  duty_out,  32'h4080);

    // release to idle
    gate = 1'b0;
    step();
    check("s2_release", env_state, 4);
    run(16);
    check("s2_state",  env_state, 0);
    check("s2_active", active,    0);
    check("s2_duty",   duty_out,  0);

    // instant rates
    attack_rate = 8'd0; decay_rate = 8'd0; sustain_level = 8'd255;
    note_duty = 16'hBEEF;
    gate = 1'b1;
    run(12);
    check("s3_state", env_state, 3);
    check("s3_level", env_level, 255);
    check("s3_duty",  duty_out,  32'hBEEF);

    // retrigger during release at level 100
    release_rate = 8'd155;
    gate = 1'b0;
    k = 0;
    while (!(m_state == 4 && m_level == 100) && k < 40) begin step(); k++; end
    check("s4_reach", (m_state == 4 && m_level == 100) ? 1 : 0, 1);
    gate = 1'b1;
    step();
    check("s4_state", env_state, 1);
`ifdef ADSR_RETRIGGER_EN
    check("s4_level", env_level, 0);
`else
    check("s4_level", env_level, 100);
`endif

    // fall coincident with a tick
    attack_rate = 8'd1;
    k = 0;
    while (((edge_n + 1) % P) != 0 && k < 2 * P) begin step(); k++; end
    saved = m_level;
    gate = 1'b0;
    step();
    check("s5_state", env_state, 4);
    check("s5_level", env_level, saved);

    // asynchronous reset mid-attack
    gate = 1'b1;
    run(6);
    check("s6_pre", env_state, 1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_level",  env_level, 0);
    check("s6_state",  env_state, 0);
    check("s6_active", active,    0);
    check("s6_duty",   duty_out,  0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();
    check("s6_rise", env_state, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) gate = ~gate;
      if ($urandom_range(0, 39) == 0) begin
        attack_rate   = pick_rate();
        decay_rate    = pick_rate();
        release_rate  = pick_rate();
        sustain_level = 8'($urandom);
      end
      if ($urandom_range(0, 99) == 0) note_duty = 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
